// File: rtl/pc_sequencer.sv
// Program counter sequencer with branches, relative/absolute jumps and a return-address stack.
// Latency: one cycle from op to p_ct update; all outputs come straight from registers.
// Backpressure: stall=1 freezes all state; in HALTED only reset has any effect.
//
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   stall               hold all state this cycle
//   op                  0 SEQ, 1 BR_ZERO, 2 BR_LESS, 3 JMP_REL, 4 JMP_ABS, 5 CALL, 6 RET, 7 HALT
//   zero, less          status flags used by BR_ZERO / BR_LESS
//   jmp_dist            signed relative distance (two's complement)
//   jmp_target          absolute target for JMP_ABS and CALL
//   p_ct                current program counter
//   halted              high while in HALTED
//   ras_ovf, ras_unf    sticky stack overflow / underflow flags
//   ras_cnt             number of valid return-stack entries
module pc_sequencer #(
  parameter int PC_W      = 10,
  parameter int DIST_W    = 6,
  parameter int RAS_DEPTH = 4,
  parameter int RESET_PC  = 0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           stall,
  input  logic [2:0]                     op,
  input  logic                           zero,
  input  logic                           less,
  input  logic [DIST_W-1:0]              jmp_dist,
  input  logic [PC_W-1:0]                jmp_target,
  output logic [PC_W-1:0]                p_ct,
  output logic                           halted,
  output logic                           ras_ovf,
  output logic                           ras_unf,
  output logic [$clog2(RAS_DEPTH+1)-1:0] ras_cnt
);

  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam int IDX_W = $clog2(RAS_DEPTH);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

  localparam logic [2:0] OP_SEQ     = 3'd0;
  localparam logic [2:0] OP_BR_ZERO = 3'd1;
  localparam logic [2:0] OP_BR_LESS = 3'd2;
  localparam logic [2:0] OP_JMP_REL = 3'd3;
  localparam logic [2:0] OP_JMP_ABS = 3'd4;
  localparam logic [2:0] OP_CALL    = 3'd5;
  localparam logic [2:0] OP_RET     = 3'd6;
  localparam logic [2:0] OP_HALT    = 3'd7;

  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic [PC_W-1:0]   stk_q [RAS_DEPTH];
  logic [PC_W-1:0]   stk_d [RAS_DEPTH];

  logic [PC_W-1:0]   pc_inc;
  logic [PC_W-1:0]   pc_rel;

  // Sign-extending size cast; the adders wrap modulo 2^PC_W with no flag.
  assign pc_inc = pc_q + PC_W'(1);
  assign pc_rel = pc_q + PC_W'($signed(jmp_dist));

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    stk_d   = stk_q;

    if (state_q == RUN && !stall) begin
      case (op)
        OP_SEQ:     pc_d = pc_inc;
        OP_BR_ZERO: pc_d = zero ? pc_rel : pc_inc;
        OP_BR_LESS: pc_d = less ? pc_rel : pc_inc;
        OP_JMP_REL: pc_d = pc_rel;
        OP_JMP_ABS: pc_d = jmp_target;
        OP_CALL: begin
          if (cnt_q == CNT_FULL) begin
            // Full: slide entries toward index 0 so the oldest falls off the
            // bottom and the new return address lands on top.
            for (int i = 0; i < RAS_DEPTH - 1; i++) begin
              stk_d[i] = stk_q[i+1];
            end
            stk_d[RAS_DEPTH-1] = pc_inc;
            ovf_d = 1'b1;
          end else begin
            stk_d[IDX_W'(cnt_q)] = pc_inc;
            cnt_d = cnt_q + CNT_W'(1);
          end
          pc_d = jmp_target;
        end
        OP_RET: begin
          if (cnt_q != '0) begin
            pc_d  = stk_q[IDX_W'(cnt_q - CNT_W'(1))];
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            // Nothing to return to: flag it and fall through to the next PC.
            unf_d = 1'b1;
            pc_d  = pc_inc;
          end
        end
        OP_HALT:    state_d = HALTED;
        default:    pc_d = pc_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      pc_q    <= PC_W'(RESET_PC);
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Stack storage carries no reset; ras_cnt alone marks which entries are valid.
  always_ff @(posedge clk) begin
    stk_q <= stk_d;
  end

  assign p_ct    = pc_q;
  assign halted  = (state_q == HALTED);
  assign ras_ovf = ovf_q;
  assign ras_unf = unf_q;
  assign ras_cnt = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  localparam logic [2:0] SEQ = 3'd0, BRZ = 3'd1, BRL = 3'd2, JREL = 3'd3;
  localparam logic [2:0] JABS = 3'd4, CALL = 3'd5, RET = 3'd6, HALT = 3'd7;

  logic       clk = 1'b0;
  logic       reset;
  logic       stall;
  logic [2:0] op;
  logic       zero;
  logic       less;
  logic [5:0] jmp_dist;
  logic [9:0] jmp_target;
  logic [9:0] p_ct;
  logic       halted;
  logic       ras_ovf;
  logic       ras_unf;
  logic [2:0] ras_cnt;

  int n_cmp = 0;
  int n_err = 0;

  pc_sequencer #(.PC_W(10), .DIST_W(6), .RAS_DEPTH(4), .RESET_PC(0)) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .op         (op),
    .zero       (zero),
    .less       (less),
    .jmp_dist   (jmp_dist),
    .jmp_target (jmp_target),
    .p_ct       (p_ct),
    .halted     (halted),
    .ras_ovf    (ras_ovf),
    .ras_unf    (ras_unf),
    .ras_cnt    (ras_cnt)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] o, input logic [9:0] tgt, input logic [5:0] d);
    op = o; jmp_target = tgt; jmp_dist = d;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; op = SEQ; zero = 1'b0; less = 1'b0;
    jmp_dist = '0; jmp_target = '0;

    // Reset state, with a jump and stall pending to show reset overrides them
    stall = 1'b1; drive(JABS, 10'h155, 6'd0);
    tick();
    chk("rst_pc", 32'(p_ct), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_cnt", 32'(ras_cnt), 32'd0);
    chk("rst_ovf", 32'(ras_ovf), 32'd0);
    chk("rst_unf", 32'(ras_unf), 32'd0);

    // Sequential counting
    reset = 1'b0; stall = 1'b0; drive(SEQ, 10'd0, 6'd0);
    tick(); chk("seq1", 32'(p_ct), 32'd1);
    tick(); chk("seq2", 32'(p_ct), 32'd2);
    tick(); chk("seq3", 32'(p_ct), 32'd3);

    // BR_ZERO taken backward by 2, then not taken
    drive(JABS, 10'd5, 6'd0); tick(); chk("jabs5", 32'(p_ct), 32'd5);
    drive(BRZ, 10'd0, 6'b111110); zero = 1'b1;
    tick(); chk("brz_taken", 32'(p_ct), 32'd3);
    drive(JABS, 10'd5, 6'd0); tick();
    drive(BRZ, 10'd0, 6'b111110); zero = 1'b0;
    tick(); chk("brz_not", 32'(p_ct), 32'd6);

    // BR_LESS uses less only (zero held high while less is low)
    drive(BRL, 10'd0, 6'd3); less = 1'b1; zero = 1'b0;
    tick(); chk("brl_taken", 32'(p_ct), 32'd9);
    less = 1'b0; zero = 1'b1;
    tick(); chk("brl_not", 32'(p_ct), 32'd10);
    zero = 1'b0;

    // Wrap in both directions, no flags
    drive(JABS, 10'd1023, 6'd0); tick(); chk("jabs1023", 32'(p_ct), 32'd1023);
    drive(SEQ, 10'd0, 6'd0); tick();
    chk("wrap_up", 32'(p_ct), 32'd0);
    chk("wrap_up_ovf", 32'(ras_ovf), 32'd0);
    chk("wrap_up_unf", 32'(ras_unf), 32'd0);
    drive(JREL, 10'd0, 6'b111111); tick(); chk("wrap_dn", 32'(p_ct), 32'd1023);
    drive(JREL, 10'd0, 6'd5); tick(); chk("wrap_fwd", 32'(p_ct), 32'd4);

    // Stall freezes everything
    stall = 1'b1; drive(JABS, 10'd200, 6'd0);
    tick(); chk("stall_pc", 32'(p_ct), 32'd4);
    drive(CALL, 10'd300, 6'd0);
    tick(); chk("stall_call_pc", 32'(p_ct), 32'd4); chk("stall_call_cnt", 32'(ras_cnt), 32'd0);
    stall = 1'b0;

    // Single CALL / RET
    drive(JABS, 10'h010, 6'd0); tick();
    drive(CALL, 10'h100, 6'd0); tick();
    chk("call_pc", 32'(p_ct), 32'h100); chk("call_cnt", 32'(ras_cnt), 32'd1);
    drive(RET, 10'd0, 6'd0); tick();
    chk("ret_pc", 32'(p_ct), 32'h011); chk("ret_cnt", 32'(ras_cnt), 32'd0);

    // Five nested CALLs from 0x011: pushes 0x12,0x21,0x41,0x61,0x81
    drive(CALL, 10'h020, 6'd0); tick();
    drive(CALL, 10'h040, 6'd0); tick();
    drive(CALL, 10'h060, 6'd0); tick();
    drive(CALL, 10'h080, 6'd0); tick();
    chk("call4_cnt", 32'(ras_cnt), 32'd4); chk("call4_ovf", 32'(ras_ovf), 32'd0);
    drive(CALL, 10'h0A0, 6'd0); tick();
    chk("call5_pc", 32'(p_ct), 32'h0A0);
    chk("call5_cnt", 32'(ras_cnt), 32'd4);
    chk("call5_ovf", 32'(ras_ovf), 32'd1);

    // Stalled RET changes nothing
    stall = 1'b1; drive(RET, 10'd0, 6'd0); tick();
    chk("stall_ret_pc", 32'(p_ct), 32'h0A0); chk("stall_ret_cnt", 32'(ras_cnt), 32'd4);
    stall = 1'b0;

    // Five RETs: LIFO, oldest (0x12) was discarded
    tick(); chk("ret1_pc", 32'(p_ct), 32'h081); chk("ret1_cnt", 32'(ras_cnt), 32'd3);
    tick(); chk("ret2_pc", 32'(p_ct), 32'h061); chk("ret2_cnt", 32'(ras_cnt), 32'd2);
    tick(); chk("ret3_pc", 32'(p_ct), 32'h041); chk("ret3_cnt", 32'(ras_cnt), 32'd1);
    tick(); chk("ret4_pc", 32'(p_ct), 32'h021); chk("ret4_cnt", 32'(ras_cnt), 32'd0);
    chk("ret4_unf", 32'(ras_unf), 32'd0);
    tick(); chk("ret5_pc", 32'(p_ct), 32'h022); chk("ret5_cnt", 32'(ras_cnt), 32'd0);
    chk("ret5_unf", 32'(ras_unf), 32'd1);
    chk("ret5_ovf_sticky", 32'(ras_ovf), 32'd1);

    // Sticky flags survive ordinary ops
    drive(SEQ, 10'd0, 6'd0); tick();
    chk("sticky_unf", 32'(ras_unf), 32'd1); chk("sticky_ovf", 32'(ras_ovf), 32'd1);

    // Mid-sequence reset clears flags
    reset = 1'b1; tick(); reset = 1'b0;
    chk("rst2_pc", 32'(p_ct), 32'd0);
    chk("rst2_ovf", 32'(ras_ovf), 32'd0); chk("rst2_unf", 32'(ras_unf), 32'd0);

    // HALT at 7, then everything ignored
    drive(JABS, 10'd7, 6'd0); tick();
    drive(HALT, 10'd0, 6'd0); tick();
    chk("halt_pc", 32'(p_ct), 32'd7); chk("halt_flag", 32'(halted), 32'd1);
    for (int i = 0; i < 5; i++) begin
      stall = i[0];
      op = (i == 2) ? RET : ((i == 3) ? CALL : SEQ);
      jmp_target = 10'd99; zero = 1'b1; less = 1'b1;
      tick();
      chk("halted_pc", 32'(p_ct), 32'd7);
      chk("halted_flag", 32'(halted), 32'd1);
      chk("halted_cnt", 32'(ras_cnt), 32'd0);
      chk("halted_unf", 32'(ras_unf), 32'd0);
    end

    // Reset leaves HALTED despite stall and a pending jump
    stall = 1'b1; drive(JABS, 10'd55, 6'd0); reset = 1'b1; tick();
    chk("rst3_pc", 32'(p_ct), 32'd0); chk("rst3_halted", 32'(halted), 32'd0);
    reset = 1'b0; stall = 1'b0; drive(SEQ, 10'd0, 6'd0); tick();
    chk("post_rst_seq", 32'(p_ct), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
Parameters:
REQ-001 The block SHALL have parameter PC_W, default 10, program counter width in bits.
REQ-002 The block SHALL have parameter DIST_W, default 6, relative jump distance width, two's complement.
REQ-003 The block SHALL have parameter RAS_DEPTH, default 4, return-address stack entries (>=2).
REQ-004 The block SHALL have parameter RESET_PC, default 0, p_ct value after reset.
Ports:
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on posedge clk.
REQ-006 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port stall, input, 1 bit: hold all state this cycle.
REQ-008 The block SHALL have port op, input, 3 bits: 0 SEQ, 1 BR_ZERO, 2 BR_LESS, 3 JMP_REL, 4 JMP_ABS, 5 CALL, 6 RET, 7 HALT.
REQ-009 The block SHALL have port zero, input, 1 bit: zero status flag.
REQ-010 The block SHALL have port less, input, 1 bit: less status flag.
REQ-011 The block SHALL have port jmp_dist, input, DIST_W bits: signed relative distance.
REQ-012 The block SHALL have port jmp_target, input, PC_W bits: absolute target for JMP_ABS and CALL.
REQ-013 The block SHALL have port p_ct, output, PC_W bits: current program counter (register).
REQ-014 The block SHALL have port halted, output, 1 bit: high in HALTED state.
REQ-015 The block SHALL have port ras_ovf, output, 1 bit: sticky stack-overflow flag.
REQ-016 The block SHALL have port ras_unf, output, 1 bit: sticky stack-underflow flag.
REQ-017 The block SHALL have port ras_cnt, output, $clog2(RAS_DEPTH+1) bits: valid stack entries.

Function
REQ-018 The block SHALL implement two states: RUN and HALTED; all outputs registered, one-cycle latency from op to p_ct update.
REQ-019 In RUN with stall=0, next p_ct SHALL be: SEQ p_ct+1; BR_ZERO p_ct+sext(jmp_dist) if zero else p_ct+1; BR_LESS same using less; JMP_REL p_ct+sext(jmp_dist); JMP_ABS jmp_target.
REQ-020 All PC arithmetic SHALL be modulo 2^PC_W; jmp_dist sign-extended to PC_W; wrap in either direction raises no flag.
REQ-021 CALL SHALL push p_ct+1 (mod 2^PC_W) and load jmp_target into p_ct in the same cycle.
REQ-022 CALL with ras_cnt==RAS_DEPTH SHALL discard the oldest entry, push the new one, keep ras_cnt at RAS_DEPTH, set ras_ovf, and still jump.
REQ-023 RET with ras_cnt>0 SHALL pop the newest entry into p_ct and decrement ras_cnt.
REQ-024 RET with ras_cnt==0 SHALL set ras_unf, load p_ct+1, and leave ras_cnt at 0.
REQ-025 HALT SHALL keep p_ct unchanged and enter HALTED; halted rises the following cycle.
REQ-026 In HALTED, op, stall, zero, less SHALL be ignored; p_ct, stack, and flags hold; exit only via reset.
REQ-027 stall=1 in RUN SHALL freeze p_ct, stack, ras_cnt, flags, and state, regardless of op.
REQ-028 ras_ovf and ras_unf SHALL remain set until reset.

Reset
REQ-029 reset=1 at posedge clk SHALL set p_ct=RESET_PC, state RUN, halted=0, ras_cnt=0, ras_ovf=0, ras_unf=0, overriding stall and op, including mid-sequence and in HALTED.
REQ-030 Stack entry contents SHALL NOT need reset; only ras_cnt defines validity.

Verification
REQ-031 Reset, then 3 cycles op=SEQ -> p_ct 0,1,2,3.
REQ-032 p_ct=5, op=BR_ZERO, jmp_dist=6'b111110, zero=1 -> p_ct=3; repeat from 5 with zero=0 -> p_ct=6.
REQ-033 p_ct=1023, op=SEQ -> p_ct=0, no flag change; p_ct=0, op=JMP_REL, dist=-1 -> 1023.
REQ-034 p_ct=0x010, CALL jmp_target=0x100 -> p_ct=0x100, ras_cnt=1; then RET -> p_ct=0x011, ras_cnt=0.
REQ-035 Five nested CALLs (RAS_DEPTH=4) -> ras_ovf=1, ras_cnt=4; five RETs -> four returns in LIFO order, fifth sets ras_unf and p_ct+1.
REQ-036 HALT at p_ct=7, then SEQ/stall toggling for 5 cycles -> p_ct=7, halted=1; then reset -> p_ct=0, halted=0.
